multicycle_controller: RTL

Main control FSM for the multicycle RV32I core, where the ALU, memory port, register file and PC are reused across cycles. Each cycle it decodes the instruction register fields and ALU flags into mux selects, write enables and an ALU operation. It sequences every supported instruction through fetch, decode, execute, memory and writeback states. It also flags illegal opcodes and pulses once per retired instruction so the bench can track completion.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller (master) consumes instruction fields and ALU flags and drives the control lines.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       ltu;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, lt, ltu,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt, ltu,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath selects.
module multicycle_controller (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL, S_JALR, S_JALR2,
    S_ALUWB, S_BRANCH, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  state_t state_q, state_d;

  // Only R-type honours funct7b5 for add/sub; shifts honour it in both forms.
  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic l, input logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    case (bus.op)
      OP_STORE:         bus.ImmSrc = 3'b001;
      OP_BRANCH:        bus.ImmSrc = 3'b010;
      OP_JAL:           bus.ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
      default:          bus.ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RS2;
    bus.ALUControl = ALU_ADD;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURES;
        bus.PCWrite   = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = (bus.funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc  = RES_DATA;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc     = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUSrcB    = SRCB_RS2;
        bus.ALUControl = funct_alu(bus.funct3, bus.funct7b5, 1'b1);
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = funct_alu(bus.funct3, bus.funct7b5, 1'b0);
        state_d        = S_ALUWB;
      end
      S_LUI: begin
        bus.ALUSrcA = SRCA_ZERO;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_JAL: begin
        // Target was computed into ALUOut during DECODE; ALU now forms the link.
        bus.PCWrite = 1'b1;
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        state_d     = S_ALUWB;
      end
      S_JALR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_JALR2;
      end
      S_JALR2: begin
        bus.PCWrite = 1'b1;
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUSrcB    = SRCB_RS2;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: begin
        bus.illegal = 1'b1;
        state_d     = S_ILLEGAL;
      end
    endcase

    // Reset suppresses every side effect and presents FETCH selects.
    if (reset) begin
      state_d        = S_FETCH;
      bus.PCWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = RES_ALURES;
      bus.ALUSrcA    = SRCA_PC;
      bus.ALUSrcB    = SRCB_FOUR;
      bus.ALUControl = ALU_ADD;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

endmodule
